// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for the pipelined shifter.
// The master side issues operations and consumes results; the slave side is the shifter.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_src;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_src, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_src, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined SLL/SRL/SRA/ROR shifter built as a log2(WIDTH)-level mux cascade.
// Levels run from the largest shift (2^(SHW-1)) down to 1; a register bank follows
// every REG_EVERY levels, and each bank carries data, shift amount, op, tag, the
// original sign bit and a valid flag. Backpressure ripples combinationally from
// out_ready, so empty stages keep absorbing new work while the tail is stalled.
module pipelined_shifter #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pipelined_shifter_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int L   = (SHW + REG_EVERY - 1) / REG_EVERY;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // One mux level: shift by 2^k with the fill rule of the operation.
  // The arithmetic fill uses the sign of the original operand, not the current data.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input op_e              op,
    input logic             sign,
    input int               k
  );
    int               amt;
    logic [WIDTH-1:0] fill;
    amt  = 1 << k;
    fill = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = d >> amt;
      OP_SRA:  shift_level = (d >> amt) | (sign ? fill : '0);
      default: shift_level = (d >> amt) | (d << (WIDTH - amt));
    endcase
  endfunction

  // Stage registers
  logic [L-1:0]     valid_q;
  logic [WIDTH-1:0] data_q  [L];
  logic [SHW-1:0]   sham_q  [L];
  op_e              op_q    [L];
  logic [TAG_W-1:0] tag_q   [L];
  logic             sign_q  [L];

  // Stage inputs (what each bank would capture) and shifted data
  logic [L-1:0]     in_v;
  logic [WIDTH-1:0] in_d    [L];
  logic [SHW-1:0]   in_sh   [L];
  op_e              in_op   [L];
  logic [TAG_W-1:0] in_tag  [L];
  logic             in_sg   [L];
  logic [WIDTH-1:0] nx_d    [L];
  logic [SHW-1:0]   sh_tmp;

  // Per-stage load enables and the ripple accumulator that builds them
  logic [L-1:0]     rdy;
  logic             rdy_acc;

  // Route the bus into stage 0 and each bank's outputs into the next stage.
  always_comb begin
    in_v = '0;
    for (int s = 0; s < L; s++) begin
      in_d[s]   = '0;
      in_sh[s]  = '0;
      in_op[s]  = OP_SLL;
      in_tag[s] = '0;
      in_sg[s]  = 1'b0;
    end
    in_v[0]   = bus.in_valid;
    in_d[0]   = bus.in_src;
    in_sh[0]  = bus.in_shamt;
    in_op[0]  = op_e'(bus.in_op);
    in_tag[0] = bus.in_tag;
    in_sg[0]  = bus.in_src[WIDTH-1];
    for (int s = 1; s < L; s++) begin
      in_v[s]   = valid_q[s-1];
      in_d[s]   = data_q[s-1];
      in_sh[s]  = sham_q[s-1];
      in_op[s]  = op_q[s-1];
      in_tag[s] = tag_q[s-1];
      in_sg[s]  = sign_q[s-1];
    end
  end

  // Apply the mux levels owned by each stage; level k = SHW-1-j belongs to stage j/REG_EVERY.
  always_comb begin
    sh_tmp = '0;
    for (int s = 0; s < L; s++) begin
      nx_d[s] = in_d[s];
      for (int j = 0; j < SHW; j++) begin
        if ((j / REG_EVERY) == s) begin
          sh_tmp = in_sh[s] >> (SHW - 1 - j);
          if (sh_tmp[0]) begin
            nx_d[s] = shift_level(nx_d[s], in_op[s], in_sg[s], SHW - 1 - j);
          end
        end
      end
    end
  end

  // A stage may load when it is empty or the stage after it can move on.
  always_comb begin
    rdy     = '0;
    rdy_acc = bus.out_ready;
    for (int s = L - 1; s >= 0; s--) begin
      rdy_acc = ~valid_q[s] | rdy_acc;
      rdy[s]  = rdy_acc;
    end
  end

  // Advance the pipeline; payload only changes when a real operation moves in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int s = 0; s < L; s++) begin
        data_q[s] <= '0;
        sham_q[s] <= '0;
        op_q[s]   <= OP_SLL;
        tag_q[s]  <= '0;
        sign_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        if (rdy[s]) begin
          valid_q[s] <= in_v[s];
          if (in_v[s]) begin
            data_q[s] <= nx_d[s];
            sham_q[s] <= in_sh[s];
            op_q[s]   <= in_op[s];
            tag_q[s]  <= in_tag[s];
            sign_q[s] <= in_sg[s];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = valid_q[L-1];
  assign bus.out_data  = data_q[L-1];
  assign bus.out_tag   = tag_q[L-1];

endmodule
